button_event_queue: RTL and testbench

//  Sits directly downstream of the per-button debouncers. Turns their pressed/held outputs into a queue of button events.

---
 rtl/button_event_queue_if.sv | 34 +++
 rtl/button_event_queue.sv | 154 +++++++++++++++
 tb/tb_button_event_queue.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/button_event_queue_if.sv
// ============================================================================
// Module  : button_event_queue_if
// Brief   : Valid/ready event handshake between the button event queue and its consumer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface button_event_queue_if #(
    parameter int IDX_W = 2
);
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_idx;
    logic             evt_long;
    logic             evt_multi;

    modport master (
        output evt_valid,
        output evt_idx,
        output evt_long,
        output evt_multi,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_idx,
        input  evt_long,
        input  evt_multi,
        output evt_ready
    );
endinterface

`default_nettype wire

// File: rtl/button_event_queue.sv
// ============================================================================
// Module  : button_event_queue
// Brief   : Turns debounced press pulses and hold levels into a FIFO of PRESS/LONG events.
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_event_queue #(
    parameter int NUM_BTN     = 4,
    parameter int IDX_W       = 2,
    parameter int LONG_CYCLES = 100000000,
    parameter int CNT_W       = 27,
    parameter int DEPTH       = 4,
    parameter int OCC_W       = 3
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [NUM_BTN-1:0] pressed,
    input  wire logic [NUM_BTN-1:0] held,
    input  wire logic               enable,
    button_event_queue_if.master    evt,
    output logic      [OCC_W-1:0]   occupancy,
    output logic                    overflow,
    input  wire logic               clear_overflow
);

    localparam int                c_PTR_W     = $clog2(DEPTH);
    localparam int                c_ENTRY_W   = IDX_W + 2;
    localparam logic [CNT_W-1:0]  c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [OCC_W-1:0]  c_FULL      = OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_trk_idx, w_trk_idx_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               w_long_fire;

    logic [IDX_W-1:0]   w_press_idx;
    logic               w_press_multi;
    logic               w_press_fire;

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wptr, r_rptr;
    logic [OCC_W-1:0]     r_count;
    logic                 r_overflow;
    logic [c_ENTRY_W-1:0] w_push_entry, w_head;
    logic                 w_push, w_pop, w_wr, w_drop, w_full, w_empty;

    // Lowest set bit wins: scan from the top so the last match is the lowest index.
    always_comb begin
        w_press_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pressed[i]) w_press_idx = IDX_W'(i);
        end
    end

    assign w_press_multi = |(pressed & (pressed - NUM_BTN'(1)));
    assign w_press_fire  = enable & (|pressed);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_trk_idx <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_trk_idx <= w_trk_idx_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // A new press always retargets the tracker and masks any LONG due this cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_trk_idx_nxt = r_trk_idx;
        w_cnt_nxt     = r_cnt;
        w_long_fire   = 1'b0;
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (w_press_fire) begin
            w_state_nxt   = S_TRACK;
            w_trk_idx_nxt = w_press_idx;
            w_cnt_nxt     = '0;
        end else begin
            case (r_state)
                S_TRACK: begin
                    if (!held[r_trk_idx]) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_cnt == c_LONG_LAST) begin
                        w_long_fire = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (!held[r_trk_idx]) w_state_nxt = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign w_push       = w_press_fire | w_long_fire;
    assign w_push_entry = w_press_fire ? {1'b0, w_press_multi, w_press_idx}
                                       : {1'b1, 1'b0, r_trk_idx};
    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty & evt.evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr    = w_push & (!w_full | w_pop);
    assign w_drop  = w_push & w_full & !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= w_push_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_pop) r_rptr <= r_rptr + c_PTR_W'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop)              r_overflow <= 1'b1;
            else if (clear_overflow) r_overflow <= 1'b0;
        end
    end

    // Head fields are zeroed while empty so the reset view is deterministic.
    assign w_head        = r_mem[r_rptr];
    assign evt.evt_valid = !w_empty;
    assign evt.evt_idx   = w_empty ? '0   : w_head[IDX_W-1:0];
    assign evt.evt_multi = w_empty ? 1'b0 : w_head[IDX_W];
    assign evt.evt_long  = w_empty ? 1'b0 : w_head[IDX_W+1];
    assign occupancy     = r_count;
    assign overflow      = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_button_event_queue.sv
// ============================================================================
// Module  : tb_button_event_queue
// Brief   : Directed self-checking bench for button_event_queue (LONG_CYCLES=10).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_button_event_queue;

    localparam int NUM_BTN = 4;
    localparam int IDX_W   = 2;
    localparam int OCC_W   = 3;

    logic               clk;
    logic               reset;
    logic [NUM_BTN-1:0] pressed;
    logic [NUM_BTN-1:0] held;
    logic               enable;
    logic [OCC_W-1:0]   occupancy;
    logic               overflow;
    logic               clear_overflow;

    int total;
    int bad;

    button_event_queue_if #(.IDX_W(IDX_W)) evt_bus ();

    button_event_queue #(
        .NUM_BTN     (NUM_BTN),
        .IDX_W       (IDX_W),
        .LONG_CYCLES (10),
        .CNT_W       (4),
        .DEPTH       (4),
        .OCC_W       (OCC_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pressed        (pressed),
        .held           (held),
        .enable         (enable),
        .evt            (evt_bus.master),
        .occupancy      (occupancy),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int long_k;
        logic [IDX_W-1:0] long_idx;
        logic             long_kind;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        pressed = '0;
        held = '0;
        enable = 1'b1;
        clear_overflow = 1'b0;
        evt_bus.evt_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_valid", evt_bus.evt_valid, 0);
        check("rst_idx", evt_bus.evt_idx, 0);
        check("rst_long", evt_bus.evt_long, 0);
        check("rst_multi", evt_bus.evt_multi, 0);
        check("rst_occ", occupancy, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: single short press on btn0
        pressed = 4'b0001; held = 4'b0001; evt_bus.evt_ready = 1'b1;
        @(negedge clk);
        pressed = '0;
        check("t1_valid", evt_bus.evt_valid, 1);
        check("t1_idx", evt_bus.evt_idx, 0);
        check("t1_long", evt_bus.evt_long, 0);
        check("t1_multi", evt_bus.evt_multi, 0);
        @(negedge clk);
        check("t1_popped", evt_bus.evt_valid, 0);
        @(negedge clk);
        held = '0;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (evt_bus.evt_valid) n++;
        end
        check("t1_no_extra", n, 0);

        // 2: two buttons pressed in the same cycle
        evt_bus.evt_ready = 1'b0;
        pressed = 4'b0110;
        @(negedge clk);
        pressed = '0;
        check("t2_valid", evt_bus.evt_valid, 1);
        check("t2_idx", evt_bus.evt_idx, 1);
        check("t2_multi", evt_bus.evt_multi, 1);
        check("t2_long", evt_bus.evt_long, 0);
        check("t2_occ", occupancy, 1);
        @(negedge clk);
        check("t2_occ_peak", occupancy, 1);
        evt_bus.evt_ready = 1'b1;
        @(negedge clk);
        check("t2_drained", evt_bus.evt_valid, 0);

        // 3: long hold on btn3, LONG visible 10 cycles after the PRESS
        pressed = 4'b1000; held = 4'b1000;
        @(negedge clk);
        pressed = '0;
        check("t3_press_valid", evt_bus.evt_valid, 1);
        check("t3_press_idx", evt_bus.evt_idx, 3);
        check("t3_press_long", evt_bus.evt_long, 0);
        n = 0; long_k = 0; long_idx = '0; long_kind = 1'b0;
        for (int k = 2; k <= 30; k++) begin
            @(negedge clk);
            if (evt_bus.evt_valid) begin
                n++;
                long_k    = k;
                long_idx  = evt_bus.evt_idx;
                long_kind = evt_bus.evt_long;
            end
            if (k == 25) held = '0;
        end
        check("t3_long_count", n, 1);
        check("t3_long_cycle", long_k, 11);
        check("t3_long_idx", long_idx, 3);
        check("t3_long_kind", long_kind, 1);

        // 4: five presses on btn2 with no consumer
        evt_bus.evt_ready = 1'b0;
        check("t4_ovf_before", overflow, 0);
        for (int p = 0; p < 5; p++) begin
            pressed = 4'b0100;
            @(negedge clk);
            pressed = '0;
            @(negedge clk);
        end
        check("t4_occ", occupancy, 4);
        check("t4_ovf", overflow, 1);
        evt_bus.evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t4_drain_valid", evt_bus.evt_valid, 1);
            check("t4_drain_idx", evt_bus.evt_idx, 2);
            check("t4_drain_long", evt_bus.evt_long, 0);
            @(negedge clk);
        end
        check("t4_empty", evt_bus.evt_valid, 0);
        check("t4_ovf_sticky", overflow, 1);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check("t4_ovf_cleared", overflow, 0);

        // 5: push+pop when full, then clear racing a drop
        evt_bus.evt_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            pressed = 4'b0010;
            @(negedge clk);
            pressed = '0;
            @(negedge clk);
        end
        check("t5_full_occ", occupancy, 4);
        check("t5_full_ovf", overflow, 0);
        evt_bus.evt_ready = 1'b1;
        pressed = 4'b0010;
        @(negedge clk);
        pressed = '0;
        evt_bus.evt_ready = 1'b0;
        check("t5_pushpop_occ", occupancy, 4);
        check("t5_pushpop_ovf", overflow, 0);
        pressed = 4'b0001;
        clear_overflow = 1'b1;
        @(negedge clk);
        pressed = '0;
        clear_overflow = 1'b0;
        check("t5_set_wins", overflow, 1);
        check("t5_drop_occ", occupancy, 4);
        evt_bus.evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5_drain_idx", evt_bus.evt_idx, 1);
            check("t5_drain_valid", evt_bus.evt_valid, 1);
            @(negedge clk);
        end
        check("t5_empty", evt_bus.evt_valid, 0);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;

        // 6: async reset mid-hold with two queued events
        evt_bus.evt_ready = 1'b0;
        held = 4'b1000;
        pressed = 4'b1000;
        @(negedge clk);
        pressed = '0;
        @(negedge clk);
        pressed = 4'b1000;
        @(negedge clk);
        pressed = '0;
        @(negedge clk);
        check("t6_occ_before", occupancy, 2);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_valid", evt_bus.evt_valid, 0);
        check("t6_rst_occ", occupancy, 0);
        @(negedge clk);
        reset = 1'b0;
        evt_bus.evt_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (evt_bus.evt_valid) n++;
        end
        check("t6_no_long", n, 0);
        held = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
